// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if : data-memory request/grant/response bus used by the load/store unit.
//
// Signals
//   req    master->slave  access request, held until gnt
//   we     master->slave  1 = store, 0 = load
//   be     master->slave  byte enables (one per byte lane)
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated store data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read response / write acknowledge
//   rdata  slave->master  read data
//
// Modports
//   master : the load/store unit
//   slave  : the data memory (or a bench model of it)
// ---------------------------------------------------------------------------
interface lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store stage between execute and mem/wb.
//
// Accepts one executed instruction at a time. Loads and stores go out on the
// data-memory bus (dmem); everything else passes through with one cycle of
// latency. Store data is lane-replicated, load data is lane-selected and
// sign/zero extended. The stage holds ready_o low while an access is in
// flight.
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   ex_valid_i / ready_o execute-stage handshake
//   inst_i, instaddr_i   instruction word and its address
//   mem_addr_i           effective address (rs1+imm)
//   mem_wdata_i          store source (rs2)
//   regs_wen_i, rd_addr_i, rd_data_i   write-back request from execute
//   dmem                 data-memory bus (lsu_if.master)
//   wb_valid_o           one-cycle result strobe per instruction
//   inst_o, instaddr_o, regs_wen_o, rd_addr_o, rd_data_o   write-back result
//   exc_o, exc_addr_o    misaligned-access exception pulse and address
//
// Configuration
//   LSU_MISALIGN_EXC_EN  when defined, misaligned half/word accesses skip the
//                        bus and raise exc_o; otherwise the low address bits
//                        are ignored and exc_o/exc_addr_o are tied to 0.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ex_valid_i,
    output logic          ready_o,
    input  logic [31:0]   inst_i,
    input  logic [31:0]   instaddr_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic          regs_wen_i,
    input  logic [4:0]    rd_addr_i,
    input  logic [DW-1:0] rd_data_i,
    lsu_if.master         dmem,
    output logic          wb_valid_o,
    output logic [31:0]   inst_o,
    output logic [31:0]   instaddr_o,
    output logic          regs_wen_o,
    output logic [4:0]    rd_addr_o,
    output logic [DW-1:0] rd_data_o,
    output logic          exc_o,
    output logic [AW-1:0] exc_addr_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    // funct3[1:0] encodes the access size directly
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_t;

    state_t state, state_d;

    // ---------------- decode of the incoming instruction ----------------
    logic [2:0] funct3;
    logic       is_load, is_store, mem_op, legal, misaligned;
    logic       accept, start_access;

    assign funct3   = inst_i[14:12];
    assign is_load  = (inst_i[6:0] == OP_LOAD);
    assign is_store = (inst_i[6:0] == OP_STORE);
    assign mem_op   = is_load || is_store;
    assign legal    = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                      (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));

`ifdef LSU_MISALIGN_EXC_EN
    assign misaligned = legal &&
                        (((funct3[1:0] == 2'b01) && mem_addr_i[0]) ||
                         ((funct3[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign ready_o      = (state == IDLE) && rstn;
    assign accept       = ex_valid_i && ready_o;
    // Illegal funct3 and (when enabled) misaligned accesses never touch the bus.
    assign start_access = accept && legal && !misaligned;

    // ---------------- captured access ----------------
    logic [AW-1:0] addr_q;
    size_t         size_q;
    logic          unsigned_q;
    logic          store_q;
    logic [DW-1:0] wdata_q;
    logic          regs_wen_q;
    logic [4:0]    rd_addr_q;
    logic [31:0]   inst_q;
    logic [31:0]   instaddr_q;

    // ---------------- lane logic from captured access ----------------
    logic [3:0]    be_lane;
    logic [DW-1:0] wdata_lane;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        be_lane    = 4'b1111;
        wdata_lane = wdata_q;
        unique case (size_q)
            SZ_BYTE: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_lane    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    byte_sel = dmem.rdata[7:0];
            2'd1:    byte_sel = dmem.rdata[15:8];
            2'd2:    byte_sel = dmem.rdata[23:16];
            default: byte_sel = dmem.rdata[31:24];
        endcase
        half_sel = addr_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

        load_data = dmem.rdata;
        unique case (size_q)
            SZ_BYTE: load_data = unsigned_q ? {{(DW-8){1'b0}}, byte_sel}
                                            : {{(DW-8){byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = unsigned_q ? {{(DW-16){1'b0}}, half_sel}
                                            : {{(DW-16){half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.be    = 4'b0000;
        dmem.addr  = '0;
        dmem.wdata = '0;
        unique case (state)
            IDLE: if (start_access) state_d = REQ;
            REQ: begin
                dmem.req   = 1'b1;
                dmem.we    = store_q;
                dmem.be    = be_lane;
                dmem.addr  = {addr_q[AW-1:2], 2'b00};
                dmem.wdata = wdata_lane;
                if (dmem.gnt) state_d = WAIT;
            end
            WAIT: if (dmem.rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- capture and write-back registers ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the capture registers are reset along with the outputs;
            // there are only a handful, and it keeps the bus lanes and
            // write-back values deterministic out of reset.
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            regs_wen_q <= 1'b0;
            rd_addr_q  <= '0;
            inst_q     <= '0;
            instaddr_q <= '0;
            wb_valid_o <= 1'b0;
            inst_o     <= '0;
            instaddr_o <= '0;
            regs_wen_o <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            wb_valid_o <= 1'b0;
            if (start_access) begin
                addr_q     <= mem_addr_i;
                size_q     <= size_t'(funct3[1:0]);
                unsigned_q <= funct3[2];
                store_q    <= is_store;
                wdata_q    <= mem_wdata_i;
                regs_wen_q <= regs_wen_i;
                rd_addr_q  <= rd_addr_i;
                inst_q     <= inst_i;
                instaddr_q <= instaddr_i;
            end else if (accept) begin
                // Pass-through, illegal memory op, or trapped misaligned op:
                // result appears next cycle, memory ops never write a register.
                wb_valid_o <= 1'b1;
                inst_o     <= inst_i;
                instaddr_o <= instaddr_i;
                regs_wen_o <= regs_wen_i && !mem_op;
                rd_addr_o  <= rd_addr_i;
                rd_data_o  <= rd_data_i;
            end else if ((state == WAIT) && dmem.rvalid) begin
                wb_valid_o <= 1'b1;
                inst_o     <= inst_q;
                instaddr_o <= instaddr_q;
                regs_wen_o <= regs_wen_q && !store_q;
                rd_addr_o  <= rd_addr_q;
                rd_data_o  <= store_q ? '0 : load_data;
            end
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            exc_o      <= 1'b0;
            exc_addr_o <= '0;
        end else begin
            exc_o <= accept && misaligned;
            if (accept && misaligned) exc_addr_o <= mem_addr_i;
        end
    end
`else
    assign exc_o      = 1'b0;
    assign exc_addr_o = '0;
`endif

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : directed self-checking bench for lsu.
// Drives the data-memory bus by hand (grant/response delays chosen per step)
// and compares outputs #1 after each rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid_i;
    logic        ready_o;
    logic [31:0] inst_i, instaddr_i, mem_addr_i, mem_wdata_i;
    logic        regs_wen_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        wb_valid_o;
    logic [31:0] inst_o, instaddr_o;
    logic        regs_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        exc_o;
    logic [31:0] exc_addr_o;

    int total = 0;
    int bad   = 0;
    int low;

    lsu_if #(.AW(32), .DW(32)) bus ();

    lsu #(.DW(32), .AW(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .ex_valid_i (ex_valid_i),
        .ready_o    (ready_o),
        .inst_i     (inst_i),
        .instaddr_i (instaddr_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .regs_wen_i (regs_wen_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_i  (rd_data_i),
        .dmem       (bus),
        .wb_valid_o (wb_valid_o),
        .inst_o     (inst_o),
        .instaddr_o (instaddr_o),
        .regs_wen_o (regs_wen_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o),
        .exc_o      (exc_o),
        .exc_addr_o (exc_addr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One load/store: accept, grant after gd stall cycles, respond after rd
    // stall cycles. Checks bus fields during REQ and the result strobe.
    // 'stall' returns how many post-accept cycles ready_o was low.
    task automatic mem_op(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gd, input int rd,
                          input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          output int stall);
        ex_valid_i  = 1'b1;
        inst_i      = inst;
        instaddr_i  = 32'h0000_0400;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        regs_wen_i  = 1'b1;
        rd_addr_i   = 5'd7;
        rd_data_i   = 32'hDEAD_0000;
        tick();
        ex_valid_i = 1'b0;
        stall = 0;
        for (int i = 0; i <= gd; i++) begin
            check({tag, "_req"}, {31'd0, bus.req}, 32'd1);
            check({tag, "_addr"}, bus.addr, exp_addr);
            if (i == 0) begin
                check({tag, "_we"}, {31'd0, bus.we}, {31'd0, exp_we});
                check({tag, "_be"}, {28'd0, bus.be}, {28'd0, exp_be});
                check({tag, "_wdata"}, bus.wdata, exp_wdata);
                check({tag, "_wbv_busy"}, {31'd0, wb_valid_o}, 32'd0);
            end
            if (!ready_o) stall++;
            bus.gnt = (i == gd);
            tick();
            bus.gnt = 1'b0;
        end
        for (int j = 0; j <= rd; j++) begin
            if (j == 0) check({tag, "_req_drop"}, {31'd0, bus.req}, 32'd0);
            if (!ready_o) stall++;
            bus.rvalid = (j == rd);
            bus.rdata  = rdata;
            tick();
            bus.rvalid = 1'b0;
        end
        check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        check({tag, "_wbv"}, {31'd0, wb_valid_o}, 32'd1);
        check({tag, "_inst"}, inst_o, inst);
    endtask

    initial begin
        rstn        = 1'b0;
        ex_valid_i  = 1'b0;
        inst_i      = '0;
        instaddr_i  = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        regs_wen_i  = 1'b0;
        rd_addr_i   = '0;
        rd_data_i   = '0;
        bus.gnt     = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        tick();
        tick();

        // Reset state
        check("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_req", {31'd0, bus.req}, 32'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_exc", {31'd0, exc_o}, 32'd0);
        rstn = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, ready_o}, 32'd1);

        // Pass-through ADDI x1, x0, 0x55, then a back-to-back second one
        ex_valid_i = 1'b1;
        inst_i     = 32'h0550_0093;
        instaddr_i = 32'h0000_0100;
        regs_wen_i = 1'b1;
        rd_addr_i  = 5'd1;
        rd_data_i  = 32'h0000_0055;
        tick();
        check("pt_wbv", {31'd0, wb_valid_o}, 32'd1);
        check("pt_rd_data", rd_data_o, 32'h0000_0055);
        check("pt_wen", {31'd0, regs_wen_o}, 32'd1);
        check("pt_rd_addr", {27'd0, rd_addr_o}, 32'd1);
        check("pt_instaddr", instaddr_o, 32'h0000_0100);
        check("pt_no_req", {31'd0, bus.req}, 32'd0);
        inst_i    = 32'h0660_0113;
        rd_addr_i = 5'd2;
        rd_data_i = 32'h0000_0066;
        tick();
        check("pt2_wbv", {31'd0, wb_valid_o}, 32'd1);
        check("pt2_rd_data", rd_data_o, 32'h0000_0066);
        ex_valid_i = 1'b0;
        tick();
        check("idle_wbv_fall", {31'd0, wb_valid_o}, 32'd0);
        check("idle_rd_hold", rd_data_o, 32'h0000_0066);

        // SB 0xAB to 0x1002, immediate grant and response
        mem_op("sb", 32'h0000_0023, 32'h0000_1002, 32'h1234_56AB, 0, 0, 32'h0,
               1'b1, 4'b0100, 32'h0000_1000, 32'hABAB_ABAB, low);
        check("sb_stall", low, 2);
        check("sb_wen", {31'd0, regs_wen_o}, 32'd0);

        // LB / LBU @0x2003 with rdata 0x80FF_0000
        mem_op("lb", 32'h0000_0003, 32'h0000_2003, 32'h0, 0, 0, 32'h80FF_0000,
               1'b0, 4'b1000, 32'h0000_2000, 32'h0, low);
        check("lb_data", rd_data_o, 32'hFFFF_FF80);
        check("lb_wen", {31'd0, regs_wen_o}, 32'd1);
        check("lb_rd_addr", {27'd0, rd_addr_o}, 32'd7);
        mem_op("lbu", 32'h0000_4003, 32'h0000_2003, 32'h0, 0, 0, 32'h80FF_0000,
               1'b0, 4'b1000, 32'h0000_2000, 32'h0, low);
        check("lbu_data", rd_data_o, 32'h0000_0080);

        // LH @0x2002, grant 3 cycles late, response 2 cycles late
        mem_op("lh", 32'h0000_1003, 32'h0000_2002, 32'h0, 3, 2, 32'h9ABC_1234,
               1'b0, 4'b1100, 32'h0000_2000, 32'h0, low);
        check("lh_stall", low, 7);
        check("lh_data", rd_data_o, 32'hFFFF_9ABC);

        // LHU low half
        mem_op("lhu", 32'h0000_5003, 32'h0000_2000, 32'h0, 0, 0, 32'h9ABC_8765,
               1'b0, 4'b0011, 32'h0000_2000, 32'h0, low);
        check("lhu_data", rd_data_o, 32'h0000_8765);

        // SH to upper half, SW
        mem_op("sh", 32'h0000_1023, 32'h0000_1006, 32'h0000_5678, 0, 0, 32'h0,
               1'b1, 4'b1100, 32'h0000_1004, 32'h5678_5678, low);
        check("sh_wen", {31'd0, regs_wen_o}, 32'd0);
        mem_op("sw", 32'h0000_2023, 32'h0000_1008, 32'hCAFE_F00D, 0, 1, 32'h0,
               1'b1, 4'b1111, 32'h0000_1008, 32'hCAFE_F00D, low);
        check("sw_stall", low, 3);

        // LW with one stalled grant cycle
        mem_op("lw", 32'h0000_2003, 32'h0000_2004, 32'h0, 1, 0, 32'hDEAD_BEEF,
               1'b0, 4'b1111, 32'h0000_2004, 32'h0, low);
        check("lw_data", rd_data_o, 32'hDEAD_BEEF);
        tick();
        check("lw_wbv_fall", {31'd0, wb_valid_o}, 32'd0);
        check("lw_data_hold", rd_data_o, 32'hDEAD_BEEF);

        // Illegal load funct3 (011): no bus access, result without write
        ex_valid_i = 1'b1;
        inst_i     = 32'h0000_3003;
        mem_addr_i = 32'h0000_2000;
        regs_wen_i = 1'b1;
        tick();
        ex_valid_i = 1'b0;
        check("ill_wbv", {31'd0, wb_valid_o}, 32'd1);
        check("ill_wen", {31'd0, regs_wen_o}, 32'd0);
        check("ill_no_req", {31'd0, bus.req}, 32'd0);
        check("ill_ready", {31'd0, ready_o}, 32'd1);
        tick();

        // Reset asserted during WAIT, then a stray response
        ex_valid_i = 1'b1;
        inst_i     = 32'h0000_2003;
        mem_addr_i = 32'h0000_2000;
        tick();
        ex_valid_i = 1'b0;
        bus.gnt    = 1'b1;
        tick();
        bus.gnt = 1'b0;
        check("rw_in_wait", {31'd0, ready_o}, 32'd0);
        rstn = 1'b0;
        tick();
        check("rw_req", {31'd0, bus.req}, 32'd0);
        check("rw_wbv", {31'd0, wb_valid_o}, 32'd0);
        rstn        = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h1111_2222;
        tick();
        bus.rvalid = 1'b0;
        check("rw_stray_wbv", {31'd0, wb_valid_o}, 32'd0);
        check("rw_idle_ready", {31'd0, ready_o}, 32'd1);
        check("rw_stray_req", {31'd0, bus.req}, 32'd0);

        // Misaligned LW @0x3001
`ifdef LSU_MISALIGN_EXC_EN
        ex_valid_i = 1'b1;
        inst_i     = 32'h0000_2003;
        mem_addr_i = 32'h0000_3001;
        regs_wen_i = 1'b1;
        tick();
        ex_valid_i = 1'b0;
        check("mis_no_req", {31'd0, bus.req}, 32'd0);
        check("mis_wbv", {31'd0, wb_valid_o}, 32'd1);
        check("mis_wen", {31'd0, regs_wen_o}, 32'd0);
        check("mis_exc", {31'd0, exc_o}, 32'd1);
        check("mis_exc_addr", exc_addr_o, 32'h0000_3001);
        check("mis_ready", {31'd0, ready_o}, 32'd1);
        tick();
        check("mis_exc_pulse", {31'd0, exc_o}, 32'd0);
`else
        mem_op("mis", 32'h0000_2003, 32'h0000_3001, 32'h0, 0, 0, 32'h1122_3344,
               1'b0, 4'b1111, 32'h0000_3000, 32'h0, low);
        check("mis_data", rd_data_o, 32'h1122_3344);
        check("mis_exc", {31'd0, exc_o}, 32'd0);
        check("mis_exc_addr", exc_addr_o, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
